// File: rtl/weight_mem_sequencer.sv
// Weight memory sequencer: drives the synapse-weight memory port to bulk-load
// a full weight image from a byte stream (LOAD) or to read every entry back out
// as an address-tagged stream (SCAN). Every output is a flop.

module weight_mem_sequencer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 16   // entries per operation, at most 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_load,
    input  logic          start_scan,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoadWr,
        StScanRd,
        StScanCap,
        StScanOut,
        StDone
    } state_e;

    // Termination index; idx never wraps because the operation ends here.
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] idx_q;

    logic          in_ready_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [AW-1:0] out_addr_q;
    logic          busy_q;
    logic          done_q;

    logic          idx_last;
    logic [AW-1:0] idx_inc;

    // Index helpers shared by the load and scan paths.
    always_comb begin
        idx_last = (idx_q == LastIdx);
        idx_inc  = idx_q + 1'b1;
    end

    // Sequencer FSM; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-armed below
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    // LOAD has priority; a simultaneous scan request is dropped
                    if (start_load) begin
                        state_q    <= StLoad;
                        idx_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (start_scan) begin
                        state_q    <= StScanRd;
                        idx_q      <= '0;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end

                StLoad: begin
                    if (in_valid && in_ready_q) begin
                        state_q     <= StLoadWr;
                        in_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q;
                        mem_wdata_q <= in_data;
                    end
                end

                StLoadWr: begin
                    // write strobe lasts exactly this one cycle
                    mem_we_q <= 1'b0;
                    if (idx_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= StLoad;
                        idx_q      <= idx_inc;
                        in_ready_q <= 1'b1;
                    end
                end

                StScanRd: begin
                    // address is on the port this cycle; data returns next cycle
                    state_q    <= StScanCap;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= idx_q;
                end

                StScanCap: begin
                    state_q     <= StScanOut;
                    out_data_q  <= mem_rdata;
                    out_addr_q  <= idx_q;
                    out_valid_q <= 1'b1;
                end

                StScanOut: begin
                    // out_* hold steady until the consumer takes the word
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_last) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StScanRd;
                            idx_q      <= idx_inc;
                            mem_addr_q <= idx_inc;
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifndef SYNTHESIS
    // Each registered flag mirrors exactly one state (or its complement).
    a_we_only_in_wr : assert property (@(posedge clk) disable iff (rst)
        mem_we_q == (state_q == StLoadWr));
    a_ready_only_in_load : assert property (@(posedge clk) disable iff (rst)
        in_ready_q == (state_q == StLoad));
    a_valid_only_in_out : assert property (@(posedge clk) disable iff (rst)
        out_valid_q == (state_q == StScanOut));
    a_busy_not_idle : assert property (@(posedge clk) disable iff (rst)
        busy_q == (state_q != StIdle));
    a_done_in_done : assert property (@(posedge clk) disable iff (rst)
        done_q == (state_q == StDone));
`endif

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Bench for weight_mem_sequencer: a cycle table for start/reset corners, then
// whole LOAD/SCAN operations checked against an image-level memory model.

module tb_weight_mem_sequencer;

    localparam int DEPTH = 16;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk;
    logic       rst;
    logic       start_load;
    logic       start_scan;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_addr;
    logic       busy;
    logic       done;

    int total;
    int bad;

    logic [7:0] mem     [DEPTH];  // memory the DUT drives
    logic [7:0] ref_mem [DEPTH];  // expected memory contents
    logic [7:0] img     [DEPTH];  // image being loaded

    weight_mem_sequencer #(
        .DW   (8),
        .AW   (4),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_load(start_load),
        .start_scan(start_scan),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous weight memory with registered read data.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic       rst, sl, ss, iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_busy, e_irdy, e_we;
        logic [3:0] e_addr;
        logic [7:0] e_wdata;
        logic       c_addr, c_wdata;
        logic       e_ov;
        logic [7:0] e_odata;
        logic [3:0] e_oaddr;
        logic       c_out;
        logic       e_done;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one LOAD of img[]. gap_pct: chance the source idles; both: assert
    // start_scan with start_load; poke: pulse start_scan mid-load; abort_at:
    // reset after that many writes (-1 = run to completion).
    task automatic do_load(input int gap_pct, input logic both, input logic poke,
                           input int abort_at);
        int   k;
        int   wrote;
        int   dones;
        int   last_we;
        logic hs;
        logic prev_we;
        k = 0; wrote = 0; dones = 0; last_we = -10; prev_we = 1'b0;
        start_load = 1'b1;
        start_scan = both;
        in_valid   = (gap_pct == 0);
        in_data    = img[0];
        out_ready  = 1'b0;
        tick();
        start_load = 1'b0;
        start_scan = 1'b0;
        chkb("load_enter_busy", busy, 1'b1);
        chkb("load_enter_in_ready", in_ready, 1'b1);
        chkb("load_enter_no_out_valid", out_valid, 1'b0);
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (k < DEPTH && !in_valid && int'($urandom_range(99)) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = img[k];
            end
            hs = in_valid && in_ready;
            if (poke && cyc == 7) start_scan = 1'b1;
            tick();
            start_scan = 1'b0;
            if (hs) begin
                k++;
                in_valid = 1'b0;
            end
            if (mem_we) begin
                if (wrote < DEPTH) begin
                    chkv("load_wr_addr", 32'(mem_addr), wrote);
                    chkv("load_wr_data", 32'(mem_wdata), 32'(img[wrote]));
                end else begin
                    chkv("load_extra_write", wrote, DEPTH - 1);
                end
                chkb("load_we_one_cycle", prev_we, 1'b0);
                if (gap_pct == 0 && wrote == 0) chkv("load_first_we_edges", cyc + 1, 2);
                if (gap_pct == 0 && wrote > 0) chkv("load_we_spacing", cyc - last_we, 2);
                last_we = cyc;
                wrote++;
            end
            prev_we = mem_we;
            if (abort_at >= 0 && wrote == abort_at) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                tick();
                rst = 1'b0;
                chkb("abort_we", mem_we, 1'b0);
                chkb("abort_busy", busy, 1'b0);
                chkb("abort_in_ready", in_ready, 1'b0);
                chkb("abort_done", done, 1'b0);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chkb("abort_no_done_later", done, 1'b0);
                    chkb("abort_stays_idle", busy, 1'b0);
                end
                for (int i = 0; i < wrote; i++) ref_mem[i] = img[i];
                return;
            end
            if (done) begin
                dones++;
                chkb("load_busy_at_done", busy, 1'b1);
                chkb("load_no_we_at_done", mem_we, 1'b0);
                break;
            end
        end
        in_valid = 1'b0;
        chkv("load_write_count", wrote, DEPTH);
        chkv("load_done_count", dones, 1);
        // after done: idle, and no stray scan from ignored requests
        for (int j = 0; j < 6; j++) begin
            tick();
            chkb("load_after_busy", busy, 1'b0);
            chkb("load_after_done", done, 1'b0);
            chkb("load_after_no_scan", out_valid, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = img[i];
    endtask

    // Run one SCAN. stall_pct: chance out_ready is low; hold_addr: entry at
    // which out_ready is forced low for 5 cycles (-1 = none).
    task automatic do_scan(input int stall_pct, input int hold_addr);
        int   n;
        int   dones;
        int   stall;
        int   first_v;
        logic hs;
        logic held;
        n = 0; dones = 0; stall = 0; first_v = -1;
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        chkb("scan_enter_busy", busy, 1'b1);
        chkv("scan_enter_addr", 32'(mem_addr), 0);
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (hold_addr >= 0 && n == hold_addr && out_valid && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = (int'($urandom_range(99)) >= stall_pct);
            end
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            hs   = out_valid && out_ready;
            held = out_valid && !out_ready;
            if (hs) begin
                if (n < DEPTH) begin
                    chkv("scan_out_addr", 32'(out_addr), n);
                    chkv("scan_out_data", 32'(out_data), 32'(ref_mem[n]));
                end else begin
                    chkv("scan_extra_beat", n, DEPTH - 1);
                end
                n++;
            end
            tick();
            chkb("scan_no_we", mem_we, 1'b0);
            chkb("scan_in_ready_low", in_ready, 1'b0);
            if (held && n < DEPTH) begin
                chkb("scan_hold_valid", out_valid, 1'b1);
                chkv("scan_hold_data", 32'(out_data), 32'(ref_mem[n]));
                chkv("scan_hold_addr", 32'(out_addr), n);
                chkv("scan_hold_mem_addr", 32'(mem_addr), n);
            end
            if (first_v < 0 && out_valid) first_v = cyc;
            if (done) begin
                dones++;
                break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chkv("scan_first_valid_edges", first_v + 1, 3);
        chkv("scan_beat_count", n, DEPTH);
        chkv("scan_done_count", dones, 1);
        tick();
        chkb("scan_after_busy", busy, 1'b0);
        chkb("scan_after_done", done, 1'b0);
        chkb("scan_after_valid", out_valid, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start_load = 1'b0; start_scan = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // reset held for 2 cycles under random inputs
        for (int c = 0; c < 2; c++) begin
            start_load = 1'($urandom);
            start_scan = 1'($urandom);
            in_valid   = 1'($urandom);
            in_data    = 8'($urandom);
            out_ready  = 1'($urandom);
            tick();
        end
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b0);
        chkb("rst_we", mem_we, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkv("rst_mem_addr", 32'(mem_addr), 0);
        chkv("rst_mem_wdata", 32'(mem_wdata), 0);
        chkv("rst_out_data", 32'(out_data), 0);
        chkv("rst_out_addr", 32'(out_addr), 0);

        //            rst sl ss iv id     ordy bsy ird we adr   wdata  ca cw ov odata  oadr  co dn
        tbl[0]  = '{T, F, F, F, 8'h00, F, F, F, F, 4'd0, 8'h00, T, T, F, 8'h00, 4'd0, T, F};
        tbl[1]  = '{F, F, F, F, 8'h00, F, F, F, F, 4'd0, 8'h00, T, T, F, 8'h00, 4'd0, T, F};
        tbl[2]  = '{F, T, T, F, 8'h00, F, T, T, F, 4'd0, 8'h00, F, F, F, 8'h00, 4'd0, F, F};
        tbl[3]  = '{F, F, F, F, 8'h00, F, T, T, F, 4'd0, 8'h00, F, F, F, 8'h00, 4'd0, F, F};
        tbl[4]  = '{F, F, F, T, 8'h11, F, T, F, T, 4'd0, 8'h11, T, T, F, 8'h00, 4'd0, F, F};
        tbl[5]  = '{F, F, T, F, 8'h00, F, T, T, F, 4'd0, 8'h00, F, F, F, 8'h00, 4'd0, F, F};
        tbl[6]  = '{F, F, F, T, 8'h22, F, T, F, T, 4'd1, 8'h22, T, T, F, 8'h00, 4'd0, F, F};
        tbl[7]  = '{T, F, F, T, 8'h33, T, F, F, F, 4'd0, 8'h00, T, T, F, 8'h00, 4'd0, T, F};
        tbl[8]  = '{F, F, T, T, 8'h44, F, T, F, F, 4'd0, 8'h00, T, F, F, 8'h00, 4'd0, F, F};
        tbl[9]  = '{F, F, F, F, 8'h00, F, T, F, F, 4'd0, 8'h00, T, F, F, 8'h00, 4'd0, F, F};
        tbl[10] = '{F, F, F, F, 8'h00, F, T, F, F, 4'd0, 8'h00, T, F, T, 8'h11, 4'd0, T, F};
        tbl[11] = '{F, F, F, F, 8'h00, F, T, F, F, 4'd0, 8'h00, T, F, T, 8'h11, 4'd0, T, F};
        tbl[12] = '{F, F, F, F, 8'h00, T, T, F, F, 4'd1, 8'h00, T, F, F, 8'h00, 4'd0, F, F};
        tbl[13] = '{T, F, F, F, 8'h00, F, F, F, F, 4'd0, 8'h00, T, T, F, 8'h00, 4'd0, T, F};

        for (int i = 0; i < 14; i++) begin
            rst        = tbl[i].rst;
            start_load = tbl[i].sl;
            start_scan = tbl[i].ss;
            in_valid   = tbl[i].iv;
            in_data    = tbl[i].id;
            out_ready  = tbl[i].ordy;
            tick();
            chkb($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chkb($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_irdy);
            chkb($sformatf("vec%0d_we", i), mem_we, tbl[i].e_we);
            chkb($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chkb($sformatf("vec%0d_done", i), done, tbl[i].e_done);
            if (tbl[i].c_addr)
                chkv($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
            if (tbl[i].c_wdata)
                chkv($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wdata));
            if (tbl[i].c_out) begin
                chkv($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_odata));
                chkv($sformatf("vec%0d_out_addr", i), 32'(out_addr), 32'(tbl[i].e_oaddr));
            end
        end
        rst = 1'b0; start_load = 1'b0; start_scan = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // full load of 0xA0..0xAF with continuous valid, then scans
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'hA0 + i);
        do_load(0, F, F, -1);
        do_scan(0, -1);
        do_scan(0, 3);

        // start collision plus an ignored scan request mid-load
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_load(0, T, T, -1);
        do_scan(30, -1);

        // reset after 5 bytes keeps the partial writes; next load restarts at 0
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_load(0, F, F, 5);
        do_scan(0, -1);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_load(40, F, F, -1);
        do_scan(40, 5);

        // random images, source gaps and consumer stalls
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            do_load(int'($urandom_range(70)), F, F, -1);
            do_scan(int'($urandom_range(70)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
